// File: rtl/program_loader.sv
// Boot-time loader: packs a valid/ready byte stream into instructions, writes them
// to consecutive program-memory addresses and checks a trailing XOR checksum byte.
module program_loader #(
   parameter int ADDR_W = 8,
   parameter int INS_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              load,
   output logic [ADDR_W-1:0] load_addr,
   output logic [INS_W-1:0]  load_ins,
   output logic              busy,
   output logic              cpu_en,
   output logic              done,
   output logic [1:0]        err
);

   localparam int LO_W = INS_W - 8;
   // Bits of the low byte that have no place in the instruction word.
   localparam logic [7:0] FMT_MASK = 8'hFF << LO_W;

   typedef enum logic [1:0] {IDLE, HI, LO, CHK} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        csum_q, csum_d;
   logic              load_q, load_d;
   logic [ADDR_W-1:0] load_addr_q, load_addr_d;
   logic [INS_W-1:0]  load_ins_q, load_ins_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [1:0]        err_q, err_d;
   logic              xfer;

   assign xfer = in_valid & busy_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      hi_d        = hi_q;
      csum_d      = csum_q;
      load_d      = 1'b0;
      load_addr_d = load_addr_q;
      load_ins_d  = load_ins_q;
      done_d      = 1'b0;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               err_d = 2'b00;
               if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  csum_d      = 8'h00;
                  addr_d      = base_addr;
                  remaining_d = count;
                  state_d     = HI;
               end
            end
         end
         HI: begin
            if (xfer) begin
               hi_d    = in_data;
               csum_d  = csum_q ^ in_data;
               state_d = LO;
            end
         end
         LO: begin
            if (xfer) begin
               if (|(in_data & FMT_MASK)) err_d[1] = 1'b1;
               csum_d      = csum_q ^ in_data;
               load_d      = 1'b1;
               load_addr_d = addr_q;
               load_ins_d  = {hi_q, in_data[LO_W-1:0]};
               addr_d      = addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               state_d     = (remaining_q == (ADDR_W+1)'(1)) ? CHK : HI;
            end
         end
         CHK: begin
            if (xfer) begin
               if (in_data != csum_q) err_d[0] = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // in_ready and busy both follow the next state so they are registered.
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         hi_q        <= '0;
         csum_q      <= '0;
         load_q      <= 1'b0;
         load_addr_q <= '0;
         load_ins_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         hi_q        <= hi_d;
         csum_q      <= csum_d;
         load_q      <= load_d;
         load_addr_q <= load_addr_d;
         load_ins_q  <= load_ins_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = busy_q;
   assign busy      = busy_q;
   assign cpu_en    = ~busy_q;
   assign load      = load_q;
   assign load_addr = load_addr_q;
   assign load_ins  = load_ins_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: each task drives one scenario
// and compares observed outputs against hand-computed values.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  base_addr = 8'h00;
   logic [8:0]  count = 9'd0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, load, busy, cpu_en, done;
   logic [7:0]  load_addr;
   logic [11:0] load_ins;
   logic [1:0]  err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int cpu_bad = 0;
   int timeouts = 0;
   logic [7:0]  wr_addr[$];
   logic [11:0] wr_ins[$];
   int          wr_cyc[$];

   program_loader #(.ADDR_W(8), .INS_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .load(load),
      .load_addr(load_addr), .load_ins(load_ins), .busy(busy), .cpu_en(cpu_en),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write/done log sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (load === 1'b1) begin
         wr_addr.push_back(load_addr);
         wr_ins.push_back(load_ins);
         wr_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (cpu_en !== ~busy) cpu_bad <= cpu_bad + 1;
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_ins.delete();
      wr_cyc.delete();
      done_cnt = 0;
      cpu_bad  = 0;
      timeouts = 0;
   endtask

   task automatic do_start(input logic [7:0] b, input logic [8:0] c);
      start = 1'b1; base_addr = b; count = c;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1; in_data = b;
      while (1) begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         n++;
         if (n > 20) begin timeouts++; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_five(input logic [7:0] b0, b1, b2, b3, b4);
      send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
      n_cmp++; if (load !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_load: got %b expected 0", load); end
      n_cmp++; if (load_addr !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_load_addr: got %h expected 00", load_addr); end
      n_cmp++; if (load_ins !== 12'h000) begin n_bad++; $display("[TB] FAIL reset_load_ins: got %h expected 000", load_ins); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (cpu_en !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_cpu_en: got %b expected 1", cpu_en); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      n_cmp++; if (err !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_err: got %b expected 00", err); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_load();
      int s;
      clear_log();
      do_start(8'h10, 9'd2);
      s = cyc;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_busy_after_start: got %b expected 1", busy); end
      n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_cpu_en_after_start: got %b expected 0", cpu_en); end
      send_five(8'hAB, 8'h0C, 8'h12, 8'h03, 8'hB6);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_done_now: got %b expected 1", done); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_busy_end: got %b expected 0", busy); end
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (wr_addr.size() !== 2) begin n_bad++; $display("[TB] FAIL basic_write_count: got %0d expected 2", wr_addr.size()); end
      if (wr_addr.size() >= 2) begin
         n_cmp++; if (wr_addr[0] !== 8'h10) begin n_bad++; $display("[TB] FAIL basic_addr0: got %h expected 10", wr_addr[0]); end
         n_cmp++; if (wr_ins[0] !== 12'hABC) begin n_bad++; $display("[TB] FAIL basic_ins0: got %h expected ABC", wr_ins[0]); end
         n_cmp++; if (wr_addr[1] !== 8'h11) begin n_bad++; $display("[TB] FAIL basic_addr1: got %h expected 11", wr_addr[1]); end
         n_cmp++; if (wr_ins[1] !== 12'h123) begin n_bad++; $display("[TB] FAIL basic_ins1: got %h expected 123", wr_ins[1]); end
         n_cmp++; if (wr_cyc[0] !== s + 2) begin n_bad++; $display("[TB] FAIL basic_write0_latency: got %0d expected %0d", wr_cyc[0] - s, 2); end
         n_cmp++; if (wr_cyc[1] !== s + 4) begin n_bad++; $display("[TB] FAIL basic_write1_latency: got %0d expected %0d", wr_cyc[1] - s, 4); end
      end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt); end
      n_cmp++; if (done_cyc !== s + 5) begin n_bad++; $display("[TB] FAIL basic_done_latency: got %0d expected 5", done_cyc - s); end
      n_cmp++; if (err !== 2'b00) begin n_bad++; $display("[TB] FAIL basic_err: got %b expected 00", err); end
      n_cmp++; if (cpu_bad !== 0) begin n_bad++; $display("[TB] FAIL basic_cpu_en_vs_busy: got %0d bad cycles expected 0", cpu_bad); end
      n_cmp++; if (timeouts !== 0) begin n_bad++; $display("[TB] FAIL basic_handshake_timeout: got %0d expected 0", timeouts); end
   endtask

   task automatic test_checksum_error();
      clear_log();
      do_start(8'h10, 9'd2);
      send_five(8'hAB, 8'h0C, 8'h12, 8'h03, 8'hB7);
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (wr_addr.size() !== 2) begin n_bad++; $display("[TB] FAIL chk_write_count: got %0d expected 2", wr_addr.size()); end
      if (wr_ins.size() >= 2) begin
         n_cmp++; if (wr_ins[1] !== 12'h123) begin n_bad++; $display("[TB] FAIL chk_ins1: got %h expected 123", wr_ins[1]); end
      end
      n_cmp++; if (err !== 2'b01) begin n_bad++; $display("[TB] FAIL chk_err: got %b expected 01", err); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL chk_done_count: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_zero_count();
      clear_log();
      do_start(8'h33, 9'd0);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("[TB] FAIL zero_done: got %b expected 1", done); end
      n_cmp++; if (err !== 2'b00) begin n_bad++; $display("[TB] FAIL zero_err_cleared: got %b expected 00", err); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL zero_busy: got %b expected 0", busy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL zero_in_ready: got %b expected 0", in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL zero_done_width: got %b expected 0", done); end
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (wr_addr.size() !== 0) begin n_bad++; $display("[TB] FAIL zero_no_write: got %0d expected 0", wr_addr.size()); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL zero_done_count: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_format_wrap();
      clear_log();
      do_start(8'hFF, 9'd2);
      send_five(8'h12, 8'hF4, 8'h56, 8'h07, 8'hB7);
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (wr_addr.size() !== 2) begin n_bad++; $display("[TB] FAIL fmt_write_count: got %0d expected 2", wr_addr.size()); end
      if (wr_addr.size() >= 2) begin
         n_cmp++; if (wr_addr[0] !== 8'hFF) begin n_bad++; $display("[TB] FAIL fmt_addr0: got %h expected FF", wr_addr[0]); end
         n_cmp++; if (wr_ins[0] !== 12'h124) begin n_bad++; $display("[TB] FAIL fmt_ins0: got %h expected 124", wr_ins[0]); end
         n_cmp++; if (wr_addr[1] !== 8'h00) begin n_bad++; $display("[TB] FAIL fmt_addr1_wrap: got %h expected 00", wr_addr[1]); end
         n_cmp++; if (wr_ins[1] !== 12'h567) begin n_bad++; $display("[TB] FAIL fmt_ins1: got %h expected 567", wr_ins[1]); end
      end
      n_cmp++; if (err !== 2'b10) begin n_bad++; $display("[TB] FAIL fmt_err: got %b expected 10", err); end
   endtask

   task automatic test_stalls();
      int stalls[5];
      logic [7:0] bytes[5];
      stalls = '{2, 0, 5, 3, 1};
      bytes  = '{8'hAB, 8'h0C, 8'h12, 8'h03, 8'hB6};
      clear_log();
      do_start(8'h10, 9'd2);
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < stalls[i]; k++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_in_ready: byte %0d got %b expected 1", i, in_ready); end
            @(posedge clk); #1;
         end
         send_byte(bytes[i]);
      end
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (wr_addr.size() !== 2) begin n_bad++; $display("[TB] FAIL stall_write_count: got %0d expected 2", wr_addr.size()); end
      if (wr_addr.size() >= 2) begin
         n_cmp++; if (wr_ins[0] !== 12'hABC) begin n_bad++; $display("[TB] FAIL stall_ins0: got %h expected ABC", wr_ins[0]); end
         n_cmp++; if (wr_addr[1] !== 8'h11) begin n_bad++; $display("[TB] FAIL stall_addr1: got %h expected 11", wr_addr[1]); end
         n_cmp++; if (wr_ins[1] !== 12'h123) begin n_bad++; $display("[TB] FAIL stall_ins1: got %h expected 123", wr_ins[1]); end
      end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL stall_done_count: got %0d expected 1", done_cnt); end
      n_cmp++; if (err !== 2'b00) begin n_bad++; $display("[TB] FAIL stall_err: got %b expected 00", err); end
   endtask

   task automatic test_reset_mid_load();
      clear_log();
      do_start(8'h10, 9'd2);
      send_byte(8'hAB); send_byte(8'h0C); send_byte(8'h12);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
      n_cmp++; if (load !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_load: got %b expected 0", load); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_in_ready: got %b expected 0", in_ready); end
      n_cmp++; if (cpu_en !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mid_cpu_en: got %b expected 1", cpu_en); end
      n_cmp++; if (wr_addr.size() !== 1) begin n_bad++; $display("[TB] FAIL rst_mid_write_count: got %0d expected 1", wr_addr.size()); end
      if (wr_ins.size() >= 1) begin
         n_cmp++; if (wr_ins[0] !== 12'hABC) begin n_bad++; $display("[TB] FAIL rst_mid_ins0: got %h expected ABC", wr_ins[0]); end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_log();
      do_start(8'h10, 9'd2);
      send_five(8'hAB, 8'h0C, 8'h12, 8'h03, 8'hB6);
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (wr_addr.size() !== 2) begin n_bad++; $display("[TB] FAIL rst_reload_write_count: got %0d expected 2", wr_addr.size()); end
      if (wr_ins.size() >= 2) begin
         n_cmp++; if (wr_ins[1] !== 12'h123) begin n_bad++; $display("[TB] FAIL rst_reload_ins1: got %h expected 123", wr_ins[1]); end
      end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL rst_reload_done_count: got %0d expected 1", done_cnt); end
      n_cmp++; if (err !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_reload_err: got %b expected 00", err); end
   endtask

   task automatic test_full_depth();
      logic [7:0]  csum, hi, lo, t;
      logic [11:0] exp_w;
      int bad_addr, bad_ins;
      csum = 8'h00; bad_addr = 0; bad_ins = 0;
      clear_log();
      do_start(8'h00, 9'd256);
      for (int w = 0; w < 256; w++) begin
         hi = 8'(w);
         lo = 8'(w * 7) & 8'h0F;
         send_byte(hi);
         csum = csum ^ hi;
         if (w == 100) begin
            start = 1'b1; base_addr = 8'h80; count = 9'd5;
            @(posedge clk); #1;
            start = 1'b0;
         end
         send_byte(lo);
         csum = csum ^ lo;
      end
      send_byte(csum);
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (wr_addr.size() !== 256) begin n_bad++; $display("[TB] FAIL full_write_count: got %0d expected 256", wr_addr.size()); end
      for (int k = 0; k < 256 && k < wr_addr.size(); k++) begin
         t = 8'(k * 7);
         exp_w = {8'(k), t[3:0]};
         n_cmp++;
         if (wr_addr[k] !== 8'(k)) begin
            n_bad++; bad_addr++;
            if (bad_addr < 4) $display("[TB] FAIL full_addr[%0d]: got %h expected %h", k, wr_addr[k], 8'(k));
         end
         n_cmp++;
         if (wr_ins[k] !== exp_w) begin
            n_bad++; bad_ins++;
            if (bad_ins < 4) $display("[TB] FAIL full_ins[%0d]: got %h expected %h", k, wr_ins[k], exp_w);
         end
      end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL full_done_count: got %0d expected 1", done_cnt); end
      n_cmp++; if (err !== 2'b00) begin n_bad++; $display("[TB] FAIL full_err: got %b expected 00", err); end
      n_cmp++; if (timeouts !== 0) begin n_bad++; $display("[TB] FAIL full_handshake_timeout: got %0d expected 0", timeouts); end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_checksum_error();
      test_zero_count();
      test_format_wrap();
      test_stalls();
      test_reset_mid_load();
      test_full_depth();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time loader that sits directly upstream of the 256x12 program memory and drives its write port (load, load_addr, load_ins). It accepts a byte stream over a valid/ready handshake, packs each pair of bytes into one instruction, and writes the instructions to consecutive addresses starting at a base address. It verifies a trailing XOR checksum byte. It holds the processor off (cpu_en low) for the duration of the load.

Parameters:
ADDR_W, 8, program memory address width; depth is 2^ADDR_W.
INS_W, 12, instruction width; legal range 9..16.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a load; ignored while busy.
base_addr  input  ADDR_W  first write address, sampled on an accepted start.
count  input  ADDR_W+1  number of instructions to load, 0..2^ADDR_W, sampled on an accepted start.
in_valid  input  1  byte stream valid.
in_data  input  8  byte stream data.
in_ready  output  1  loader can accept a byte.
load  output  1  program memory write strobe.
load_addr  output  ADDR_W  program memory write address.
load_ins  output  INS_W  program memory write data.
busy  output  1  load in progress.
cpu_en  output  1  processor/program-memory read enable; equals ~busy.
done  output  1  one-cycle pulse at the end of a load.
err  output  2  bit0 = checksum mismatch, bit1 = format error; sticky until the next accepted start.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; in_ready=0, load=0, load_addr=0, load_ins=0, busy=0, cpu_en=1, done=0, err=0. A reset mid-load abandons the transfer. Memory already written is not rolled back.
- States: IDLE, HI, LO, CHK.
- Handshake: a byte transfers on a rising edge where in_valid & in_ready. in_ready is high only in HI, LO and CHK, and is registered from state. in_data is ignored without a transfer.
- IDLE, start with count=0: next cycle done=1 for one cycle and err cleared. No writes occur and the state stays IDLE.
- IDLE, start with count>0: clear err and the running checksum, latch base_addr into the address counter, latch count into the remaining counter, and go to HI. busy=1 from the next cycle.
- HI: on transfer, hold the byte as ins[INS_W-1:INS_W-8], XOR it into the checksum, and go to LO.
- LO: on transfer, the byte supplies ins[INS_W-9:0]. If byte bits [7:INS_W-8] are nonzero, set err[1]; those bits are discarded and the write still occurs. XOR the full byte into the checksum.
  - Next cycle: load=1 for exactly one cycle, with load_addr = current address and load_ins = the packed word. All three outputs are registered.
  - Address increments modulo 2^ADDR_W, so base 0xFF wraps to 0x00. Remaining decrements.
  - If remaining was 1, go to CHK; otherwise go to HI.
- Latency: the write strobe occurs 1 cycle after the LO byte transfer. Back-to-back streaming sustains 1 byte/cycle, i.e. 1 write per 2 cycles.
- CHK: on transfer, compare the byte with the running XOR and set err[0] on mismatch. Go to IDLE. Next cycle: done=1 for one cycle and busy=0.
- load is 0 in every cycle other than the write cycles; load_addr and load_ins hold their last values.
- start during HI/LO/CHK is ignored. start and reset asserted together: reset wins.
- busy=1 and cpu_en=0 in HI, LO and CHK, including the final write cycle.

Test Plan:
- Basic load: base=0x10, count=2, bytes AB,0C,12,03,B6 streamed with in_valid held high -> writes [0x10]=0xABC and [0x11]=0x123, each load pulse 1 cycle wide; done pulses once; err=00; cpu_en=0 from the cycle after start until done.
- Checksum failure: same stream with a final byte of 0xB7 -> both writes occur; err=01 after done; err clears to 00 on the next accepted start.
- Format error and address wrap: base=0xFF, count=2, bytes 12,F4,56,07,chk=(12^F4^56^07)=B7 -> writes [0xFF]=0x124 and [0x00]=0x567; err=10.
- Stalls and zero count: in_valid deasserted randomly for 0-5 cycles between bytes -> no spurious load pulses; in_ready stays high while waiting. start with count=0 -> done pulses 1 cycle later with no load pulse and busy stays 0.
- Reset mid-load: assert rst_n=0 after the third byte of the basic load -> busy, load and in_ready drop immediately and cpu_en=1; only [0x10] is written. A new start after reset completes a full load normally.
- Full depth and ignored start: count=256, base=0x00 -> 256 writes to addresses 0x00..0xFF in order; a start pulse mid-load has no effect; done pulses once.
